// File: rtl/tick_scheduler.sv
// Shares one prescaled base tick among NCH independently programmable tick channels.
// Each channel emits single-cycle clock-enable pulses in periodic or one-shot mode.
module tick_scheduler #(
    parameter int NCH      = 4,
    parameter int PRESCALE = 5000,
    parameter int PRE_W    = 13,
    parameter int PERIOD_W = 16
) (
    input  logic                clkIn,
    input  logic                rstIn_n,
    input  logic                cfgValid,
    output logic                cfgReady,
    input  logic [2:0]          cfgCh,
    input  logic [1:0]          cfgOp,
    input  logic [PERIOD_W-1:0] cfgPeriod,
    output logic [NCH-1:0]      tickOut,
    output logic [NCH-1:0]      busy,
    output logic [NCH-1:0]      done,
    output logic                cfgErr
);

    typedef enum logic [1:0] {
        OP_NOP       = 2'b00,
        OP_START_PER = 2'b01,
        OP_START_ONE = 2'b10,
        OP_STOP      = 2'b11
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [3:0]       NCH_L    = 4'(NCH);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic [NCH-1:0]      tick_q, tick_d;
    logic [NCH-1:0]      done_q, done_d;
    logic [NCH-1:0]      oneshot_q, oneshot_d;
    state_e              state_q  [NCH];
    state_e              state_d  [NCH];
    logic [PERIOD_W-1:0] period_q [NCH];
    logic [PERIOD_W-1:0] period_d [NCH];
    logic [PERIOD_W-1:0] cnt_q    [NCH];
    logic [PERIOD_W-1:0] cnt_d    [NCH];

    op_e  op;
    logic xfer, is_start, reject, cmd_ok, any_busy, base_tick;

    assign op = op_e'(cfgOp);

    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            busy[c] = (state_q[c] == ST_RUN);
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        xfer      = cfgValid & ready_q;
        is_start  = (op == OP_START_PER) || (op == OP_START_ONE);
        reject    = ({1'b0, cfgCh} >= NCH_L) || (is_start && (cfgPeriod == '0));
        cmd_ok    = xfer && !reject && (is_start || (op == OP_STOP));
        ready_d   = ~xfer;
        err_d     = xfer & reject;
        any_busy  = |busy;
        base_tick = any_busy && (pre_cnt_q == PRE_LAST);
        pre_cnt_d = (!any_busy || base_tick) ? '0 : pre_cnt_q + 1'b1;

        tick_d    = '0;
        done_d    = done_q;
        oneshot_d = oneshot_q;
        for (int c = 0; c < NCH; c++) begin
            state_d[c]  = state_q[c];
            period_d[c] = period_q[c];
            cnt_d[c]    = cnt_q[c];

            // An accepted command on this channel overrides an expiry in the same cycle.
            if (cmd_ok && (cfgCh == 3'(c))) begin
                done_d[c] = 1'b0;
                if (is_start) begin
                    state_d[c]   = ST_RUN;
                    period_d[c]  = cfgPeriod;
                    cnt_d[c]     = cfgPeriod - 1'b1;
                    oneshot_d[c] = (op == OP_START_ONE);
                end else begin
                    state_d[c] = ST_IDLE;
                    cnt_d[c]   = '0;
                end
            end else if ((state_q[c] == ST_RUN) && base_tick) begin
                if (cnt_q[c] != '0) begin
                    cnt_d[c] = cnt_q[c] - 1'b1;
                end else begin
                    tick_d[c] = 1'b1;
                    if (oneshot_q[c]) begin
                        state_d[c] = ST_IDLE;
                        done_d[c]  = 1'b1;
                    end else begin
                        cnt_d[c] = period_q[c] - 1'b1;
                    end
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clkIn or negedge rstIn_n) begin
        if (!rstIn_n) begin
            pre_cnt_q <= '0;
            ready_q   <= 1'b1;
            err_q     <= 1'b0;
            tick_q    <= '0;
            done_q    <= '0;
            oneshot_q <= '0;
            for (int c = 0; c < NCH; c++) begin
                state_q[c]  <= ST_IDLE;
                period_q[c] <= '0;
                cnt_q[c]    <= '0;
            end
        end else begin
            pre_cnt_q <= pre_cnt_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            tick_q    <= tick_d;
            done_q    <= done_d;
            oneshot_q <= oneshot_d;
            for (int c = 0; c < NCH; c++) begin
                state_q[c]  <= state_d[c];
                period_q[c] <= period_d[c];
                cnt_q[c]    <= cnt_d[c];
            end
        end
    end

    assign cfgReady = ready_q;
    assign cfgErr   = err_q;
    assign tickOut  = tick_q;
    assign done     = done_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler with PRESCALE=4, NCH=4: reset, periodic, one-shot,
// channel sharing, command errors, handshake rate and command/expiry collision.
module tb_tick_scheduler;

    localparam int NCH      = 4;
    localparam int PRESCALE = 4;
    localparam int PRE_W    = 3;
    localparam int PERIOD_W = 16;

    localparam logic [1:0] OP_NOP       = 2'b00;
    localparam logic [1:0] OP_START_PER = 2'b01;
    localparam logic [1:0] OP_START_ONE = 2'b10;
    localparam logic [1:0] OP_STOP      = 2'b11;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                cfgValid;
    logic                cfgReady;
    logic [2:0]          cfgCh;
    logic [1:0]          cfgOp;
    logic [PERIOD_W-1:0] cfgPeriod;
    logic [NCH-1:0]      tickOut;
    logic [NCH-1:0]      busy;
    logic [NCH-1:0]      done;
    logic                cfgErr;

    int n_cmp = 0;
    int n_err = 0;

    tick_scheduler #(
        .NCH      (NCH),
        .PRESCALE (PRESCALE),
        .PRE_W    (PRE_W),
        .PERIOD_W (PERIOD_W)
    ) dut (
        .clkIn     (clk),
        .rstIn_n   (rst_n),
        .cfgValid  (cfgValid),
        .cfgReady  (cfgReady),
        .cfgCh     (cfgCh),
        .cfgOp     (cfgOp),
        .cfgPeriod (cfgPeriod),
        .tickOut   (tickOut),
        .busy      (busy),
        .done      (done),
        .cfgErr    (cfgErr)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits for cfgReady, presents one command for one cycle, returns at the negedge after the accepting edge.
    task automatic cmd(input logic [2:0] ch, input logic [1:0] op, input logic [15:0] per);
        int w = 0;
        while (!cfgReady && w < 10) begin
            @(negedge clk);
            w++;
        end
        check("cmd_ready", {31'b0, cfgReady}, 32'd1);
        cfgValid  = 1'b1;
        cfgCh     = ch;
        cfgOp     = op;
        cfgPeriod = per;
        @(negedge clk);
        cfgValid  = 1'b0;
        cfgOp     = OP_NOP;
    endtask

    // Cycles until the next tickOut[ch] pulse, or -1 if none within the limit.
    task automatic next_pulse(input int ch, input int limit, output int cyc);
        cyc = -1;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (tickOut[ch]) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic hold_reset(input string tag);
        repeat (5) begin
            @(negedge clk);
            cfgValid  = 1'($urandom);
            cfgCh     = 3'($urandom);
            cfgOp     = 2'($urandom);
            cfgPeriod = 16'($urandom);
            #1;
            check(tag, {18'b0, tickOut, busy, done, cfgErr, cfgReady}, 32'd1);
        end
        @(negedge clk);
        cfgValid = 1'b0;
        cfgOp    = OP_NOP;
        rst_n    = 1'b1;
    endtask

    task automatic idle_quiet(input string tag);
        logic seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            seen |= (tickOut != '0) || (busy != '0);
        end
        check(tag, {31'b0, seen}, 32'd0);
    endtask

    initial begin
        int c;
        int n0, n1, nboth;
        logic [1:0] exp_vec;

        rst_n     = 1'b0;
        cfgValid  = 1'b0;
        cfgCh     = '0;
        cfgOp     = OP_NOP;
        cfgPeriod = '0;

        hold_reset("reset_outputs");
        idle_quiet("reset_idle_quiet");
        check("idle_ready", {31'b0, cfgReady}, 32'd1);

        // Periodic P=3: first pulse 13 cycles after the accept cycle, then every 12.
        cmd(0, OP_START_PER, 3);
        check("per_ready_drop", {31'b0, cfgReady}, 32'd0);
        check("per_busy", {28'b0, busy}, 32'h1);
        next_pulse(0, 40, c);
        check("per_first", c, 13 - 1);
        next_pulse(0, 40, c);
        check("per_space1", c, 12);
        next_pulse(0, 40, c);
        check("per_space2", c, 12);
        cmd(0, OP_STOP, 0);
        check("per_stop_busy", {28'b0, busy}, 32'h0);
        next_pulse(0, 40, c);
        check("per_after_stop", c, -1);

        // One-shot P=1: single pulse 5 cycles after accept, sets done.
        cmd(2, OP_START_ONE, 1);
        next_pulse(2, 20, c);
        check("os_first", c, 5 - 1);
        check("os_done", {28'b0, done}, 32'h4);
        check("os_busy", {28'b0, busy}, 32'h0);
        next_pulse(2, 30, c);
        check("os_single", c, -1);
        cmd(2, OP_START_ONE, 5);
        check("os_done_clear", {28'b0, done}, 32'h0);
        check("os_restart_busy", {28'b0, busy}, 32'h4);
        cmd(2, OP_STOP, 0);
        check("os_stop_busy", {28'b0, busy}, 32'h0);

        // Rejected and no-op commands.
        cmd(5, OP_START_PER, 3);
        check("err_ch_pulse", {31'b0, cfgErr}, 32'd1);
        check("err_ch_busy", {28'b0, busy}, 32'h0);
        @(negedge clk);
        check("err_ch_width", {31'b0, cfgErr}, 32'd0);
        cmd(1, OP_START_PER, 0);
        check("err_p0_pulse", {31'b0, cfgErr}, 32'd1);
        check("err_p0_busy", {28'b0, busy}, 32'h0);
        cmd(1, OP_NOP, 7);
        check("nop_no_err", {31'b0, cfgErr}, 32'd0);
        check("nop_busy", {28'b0, busy}, 32'h0);

        // Back-to-back valid: ready alternates 1,0,1,0,1.
        @(negedge clk);
        cfgValid = 1'b1;
        cfgCh    = 3'd0;
        cfgOp    = OP_NOP;
        check("b2b_ready0", {31'b0, cfgReady}, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("b2b_ready", {31'b0, cfgReady}, (k % 2 == 1) ? 32'd0 : 32'd1);
        end
        cfgValid = 1'b0;

        // Sharing: ch0 P=2 at edge k=0, ch1 P=3 at k=2 aligned to the shared phase.
        cmd(0, OP_START_PER, 2);
        cmd(1, OP_START_PER, 3);
        n0 = 0; n1 = 0; nboth = 0;
        for (int k = 2; k <= 200; k++) begin
            exp_vec = {(k >= 12) && (k % 12 == 0), (k > 0) && (k % 8 == 0)};
            check("share_vec", {30'b0, tickOut[1:0]}, {30'b0, exp_vec});
            n0    += int'(tickOut[0]);
            n1    += int'(tickOut[1]);
            nboth += int'(tickOut[0] & tickOut[1]);
            if (k < 200) @(negedge clk);
        end
        check("share_n0", n0, 25);
        check("share_n1", n1, 16);
        check("share_both", nboth, 8);
        cmd(0, OP_STOP, 0);
        cmd(1, OP_STOP, 0);
        check("share_stop_busy", {28'b0, busy}, 32'h0);

        // Collision: STOP accepted on the edge where ch0 P=1 expires.
        cmd(0, OP_START_PER, 1);
        repeat (3) @(negedge clk);
        cmd(0, OP_STOP, 0);
        check("coll_no_pulse", {31'b0, tickOut[0]}, 32'd0);
        check("coll_busy", {28'b0, busy}, 32'h0);
        next_pulse(0, 20, c);
        check("coll_quiet", c, -1);

        // Async reset in the middle of a pulse with done set.
        cmd(2, OP_START_ONE, 1);
        next_pulse(2, 20, c);
        check("rst_pre_os", c, 4);
        cmd(3, OP_START_PER, 2);
        next_pulse(3, 30, c);
        check("rst_pre_per", c, 8);
        check("rst_pre_tick", {28'b0, tickOut}, 32'h8);
        check("rst_pre_done", {28'b0, done}, 32'h4);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async", {18'b0, tickOut, busy, done, cfgErr, cfgReady}, 32'd1);
        hold_reset("rst_hold");
        idle_quiet("rst_idle_quiet");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
